// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker: FSM states,
// result-vector bit positions and datapath widths.
package gate_chk_pkg;

  // Stimulus vector {a,b}, a is the MSB.
  localparam int VEC_W     = 2;
  // Mismatching-vector counter; holds 0..4 without wrapping.
  localparam int ERR_CNT_W = 3;
  // Width of the packed gate-stage result vector.
  localparam int RES_W     = 8;

  // Bit positions inside res_in / err_mask.
  localparam int IDX_CGATE1 = 0;
  localparam int IDX_CGATE2 = 1;
  localparam int IDX_CGATE3 = 2;
  localparam int IDX_CGATE4 = 3;
  localparam int IDX_COUT1  = 4;
  localparam int IDX_COUT2  = 5;
  localparam int IDX_COUT3  = 6;
  localparam int IDX_COUT4  = 7;

  // Last vector of a sweep.
  localparam logic [VEC_W-1:0] VEC_LAST = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage : gate_chk_pkg

// File: rtl/gate_expect.sv
// Golden truth table: maps one {a,b} vector to the result vector the
// gate stage is expected to produce, in res_in packing.
module gate_expect
  import gate_chk_pkg::*;
(
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] expected
);

  // Pure combinational decode of every monitored gate output.
  always_comb begin
    expected             = '0;
    expected[IDX_CGATE1] = a & b;
    expected[IDX_CGATE2] = a | b;
    expected[IDX_CGATE3] = ~(a | b);
    expected[IDX_CGATE4] = ~(a & b);
    expected[IDX_COUT1]  = a | b;
    expected[IDX_COUT2]  = a & b;
    expected[IDX_COUT3]  = a ^ b;
    expected[IDX_COUT4]  = ~(a ^ b);
  end

endmodule : gate_expect

// File: rtl/gate_truth_checker.sv
// Sweeps the four {a,b} input vectors through an external gate stage,
// waits a programmable settle time per vector, and compares the returned
// results against the golden truth table. Reports error count, sticky
// per-bit mismatch mask, last failing vector and an overall pass flag.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned LOOP          = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 a_out,
  output logic                 b_out,
  input  logic [RES_W-1:0]     res_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [RES_W-1:0]     err_mask,
  output logic [VEC_W-1:0]     fail_vec
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] settle_cnt;
  logic [RES_W-1:0] expected;
  logic [RES_W-1:0] mismatch;
  logic             vec_bad;

  // Saturating increment so the error counter can never wrap.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

  gate_expect u_expect (
    .a        (vec[1]),
    .b        (vec[0]),
    .expected (expected)
  );

  // Per-bit disagreement between the gate stage and the golden table.
  always_comb begin
    mismatch = res_in ^ expected;
    vec_bad  = |mismatch;
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Sweep sequencer and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      err_mask   <= '0;
      fail_vec   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Stimulus is parked at 0 while idle.
          a_out <= 1'b0;
          b_out <= 1'b0;
          if (start) begin
            state    <= ST_DRIVE;
            vec      <= '0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_mask <= '0;
            fail_vec <= '0;
          end
        end

        ST_DRIVE: begin
          // Operands were loaded on entry so they are stable for the whole
          // vector window; re-registering here keeps them tied to vec.
          {a_out, b_out} <= vec;
          settle_cnt     <= SETTLE_LD;
          state          <= ST_SETTLE;
        end

        ST_SETTLE: begin
          if (settle_cnt <= CNT_W'(1)) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          if (vec_bad) begin
            err_cnt  <= sat_inc(err_cnt);
            err_mask <= err_mask | mismatch;
            fail_vec <= vec;
          end
          if (vec == VEC_LAST) begin
            // Include this final sample in the verdict.
            pass  <= (err_cnt == '0) && !vec_bad;
            state <= ST_DONE;
          end else begin
            vec            <= vec + VEC_W'(1);
            {a_out, b_out} <= vec + VEC_W'(1);
            state          <= ST_DRIVE;
          end
        end

        ST_DONE: begin
          {a_out, b_out} <= '0;
          vec            <= '0;
          if (LOOP != 0) begin
            // Automatic restart behaves exactly like an accepted start.
            state    <= ST_DRIVE;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_mask <= '0;
            fail_vec <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : gate_truth_checker

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: a behavioural gate stage with injectable
// faults feeds one single-sweep instance and one looping instance.
module tb_gate_truth_checker;

  localparam logic [7:0] GOLD [4] = '{8'h8C, 8'h5A, 8'h5A, 8'hB3};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       a0, b0, busy0, done0, pass0;
  logic [7:0] res0, err_mask0;
  logic [2:0] err_cnt0;
  logic [1:0] fail_vec0;

  logic       rst_n_l = 1'b0;
  logic       start_l = 1'b0;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] res1, err_mask1;
  logic [2:0] err_cnt1;
  logic [1:0] fail_vec1;

  logic [7:0] xor_m [4];
  logic [7:0] clr_m;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Behavioural gate stages (faulty copies are built from the golden table).
  always_comb res0 = (GOLD[{a0, b0}] ^ xor_m[{a0, b0}]) & ~clr_m;
  always_comb res1 = GOLD[{a1, b1}] ^ 8'h40;

  gate_truth_checker #(.SETTLE_CYCLES(2), .LOOP(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_out(a0), .b_out(b0),
    .res_in(res0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err_cnt0), .err_mask(err_mask0), .fail_vec(fail_vec0)
  );

  gate_truth_checker #(.SETTLE_CYCLES(2), .LOOP(1)) dut_loop (
    .clk(clk), .rst_n(rst_n_l), .start(start_l), .a_out(a1), .b_out(b1),
    .res_in(res1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err_cnt1), .err_mask(err_mask1), .fail_vec(fail_vec1)
  );

  task automatic set_faults(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] x2, input logic [7:0] x3,
                            input logic [7:0] c);
    xor_m[0] = x0; xor_m[1] = x1; xor_m[2] = x2; xor_m[3] = x3; clr_m = c;
  endtask

  // Reference: what a sweep must report given the current gate faults.
  task automatic ref_model(output int cnt, output logic [7:0] mask,
                           output logic [1:0] fv, output logic ps);
    logic [7:0] m;
    cnt = 0; mask = '0; fv = '0;
    for (int v = 0; v < 4; v++) begin
      m = ((GOLD[v] ^ xor_m[v]) & ~clr_m) ^ GOLD[v];
      if (m != 0) begin
        cnt++;
        mask = mask | m;
        fv = 2'(v);
      end
    end
    ps = (cnt == 0);
  endtask

  // Follows one sweep from cycle 1 (first cycle after the accepting edge);
  // returns at the cycle done is seen, or after a 40-cycle budget.
  task automatic watch_sweep(output int done_cyc, output int ab_err);
    logic [1:0] ev;
    done_cyc = 0; ab_err = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done0 === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (cyc <= 16) begin
        ev = 2'((cyc - 1) / 4);
        if ({a0, b0} !== ev || busy0 !== 1'b1) ab_err++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string name, input int dc, input int abe,
                              input int ecnt, input logic [7:0] emask,
                              input logic [1:0] efv, input logic eps);
    tests_run++;
    if (dc !== 17) begin tests_failed++; $display("FAIL %s done_cycle: got %0d expected 17", name, dc); end
    tests_run++;
    if (abe !== 0) begin tests_failed++; $display("FAIL %s ab_sequence: %0d bad cycles expected 0", name, abe); end
    tests_run++;
    if (err_cnt0 !== 3'(ecnt)) begin tests_failed++; $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt0, ecnt); end
    tests_run++;
    if (err_mask0 !== emask) begin tests_failed++; $display("FAIL %s err_mask: got %h expected %h", name, err_mask0, emask); end
    tests_run++;
    if (fail_vec0 !== efv) begin tests_failed++; $display("FAIL %s fail_vec: got %b expected %b", name, fail_vec0, efv); end
    tests_run++;
    if (pass0 !== eps) begin tests_failed++; $display("FAIL %s pass: got %b expected %b", name, pass0, eps); end
  endtask

  task automatic one_sweep(input string name, input int ecnt, input logic [7:0] emask,
                           input logic [1:0] efv, input logic eps);
    int dc, abe;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_sweep(dc, abe);
    check_result(name, dc, abe, ecnt, emask, efv, eps);
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++;
    if ({a0, b0, busy0, done0, pass0, err_cnt0, err_mask0, fail_vec0} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_outputs: got %h expected 0",
        {a0, b0, busy0, done0, pass0, err_cnt0, err_mask0, fail_vec0});
    end
    tests_run++;
    if ({a1, b1, busy1, done1, pass1, err_cnt1, err_mask1, fail_vec1} !== 18'd0) begin
      tests_failed++; $display("FAIL reset_outputs_loop: got %h expected 0",
        {a1, b1, busy1, done1, pass1, err_cnt1, err_mask1, fail_vec1});
    end
    rst_n = 1'b1; rst_n_l = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy0, done0);
    end
  endtask

  task automatic test_clean_sweep;
    set_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    one_sweep("clean", 0, 8'h00, 2'b00, 1'b1);
  endtask

  task automatic test_stuck_cgate3;
    set_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h04);
    one_sweep("cgate3_stuck0", 1, 8'h04, 2'b00, 1'b0);
  endtask

  task automatic test_cout3_inverted;
    set_faults(8'h40, 8'h40, 8'h40, 8'h40, 8'h00);
    one_sweep("cout3_inv", 4, 8'h40, 2'b11, 1'b0);
  endtask

  task automatic test_random;
    int cnt;
    logic [7:0] mask;
    logic [1:0] fv;
    logic ps;
    for (int n = 0; n < 12; n++) begin
      for (int v = 0; v < 4; v++) xor_m[v] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      clr_m = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ref_model(cnt, mask, fv, ps);
      one_sweep($sformatf("random%0d", n), cnt, mask, fv, ps);
    end
  endtask

  task automatic test_reset_mid;
    int seen, bad;
    set_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if ({a0, b0} === 2'b10 && busy0 === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1) begin tests_failed++; $display("FAIL reach_vec10: got %0d expected 1", seen); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a0, b0, busy0, done0, pass0, err_cnt0, err_mask0, fail_vec0} !== 18'd0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got %h expected 0",
        {a0, b0, busy0, done0, pass0, err_cnt0, err_mask0, fail_vec0});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL no_done_after_reset: %0d bad cycles expected 0", bad); end
    one_sweep("after_reset", 0, 8'h00, 2'b00, 1'b1);
  endtask

  task automatic test_held_start;
    int dc, abe, guard;
    set_faults(8'h40, 8'h40, 8'h40, 8'h40, 8'h00);
    start = 1'b1;
    @(negedge clk);
    watch_sweep(dc, abe);
    check_result("held_start", dc, abe, 4, 8'h40, 2'b11, 1'b0);
    @(negedge clk);
    tests_run++;
    if (busy0 !== 1'b0 || err_cnt0 !== 3'd4) begin
      tests_failed++; $display("FAIL held_idle_gap: busy=%b err_cnt=%0d expected busy=0 err_cnt=4", busy0, err_cnt0);
    end
    @(negedge clk);
    tests_run++;
    if (busy0 !== 1'b1 || err_cnt0 !== 3'd0 || pass0 !== 1'b0 || err_mask0 !== 8'h00) begin
      tests_failed++; $display("FAIL held_restart_clear: busy=%b err_cnt=%0d pass=%b mask=%h expected 1 0 0 00",
        busy0, err_cnt0, pass0, err_mask0);
    end
    start = 1'b0;
    guard = 0;
    while (done0 !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
    tests_run++;
    if (guard >= 40) begin tests_failed++; $display("FAIL held_second_done: got timeout expected done"); end
    @(negedge clk);
  endtask

  task automatic test_loop;
    int bad, zero_bad, cnt_bad;
    start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    bad = 0; zero_bad = 0; cnt_bad = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 17 || cyc == 34 || cyc == 51) begin
        if (done1 !== 1'b1) bad++;
        if (err_cnt1 !== 3'd4 || pass1 !== 1'b0) cnt_bad++;
      end else if (done1 !== 1'b0 || busy1 !== 1'b1) begin
        bad++;
      end
      if ((cyc == 18 || cyc == 35 || cyc == 52) && err_cnt1 !== 3'd0) zero_bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL loop_done_period: %0d bad cycles expected 0", bad); end
    tests_run++;
    if (cnt_bad !== 0) begin tests_failed++; $display("FAIL loop_err_cnt: %0d sweeps wrong expected 0", cnt_bad); end
    tests_run++;
    if (zero_bad !== 0) begin tests_failed++; $display("FAIL loop_restart_clear: %0d uncleared expected 0", zero_bad); end
    rst_n_l = 1'b0;
    #1;
    tests_run++;
    if (busy1 !== 1'b0) begin tests_failed++; $display("FAIL loop_reset: busy=%b expected 0", busy1); end
  endtask

  initial begin
    set_faults(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_clean_sweep();
    test_stuck_cgate3();
    test_cout3_inverted();
    test_random();
    test_reset_mid();
    test_held_start();
    test_loop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_gate_truth_checker
